// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus_dma copy engine: FSM encodings, register map
// word indices, CTRL bit positions and the CTRL readback packer.
package bus_dma_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    // Word index inside the 16-byte register window (byte offset >> 2).
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_ERROR = 3;

    function automatic logic [31:0] pack_ctrl(input logic        busy,
                                              input logic        done,
                                              input logic        err,
                                              input logic [15:0] remaining);
        pack_ctrl = {remaining, 12'h000, err, done, 1'b0, busy};
    endfunction

endpackage

// File: rtl/bus_dma_if.sv
// Device-side register port and host-side initiator port of bus_dma.
interface bus_dma_if;

    // Device port: a request is taken on any edge where (ren|wen)&active; ready
    // pulses for exactly the following cycle with rdata valid. Host port: m_ren /
    // m_wen hold with stable m_addr/m_wdata until m_ready is sampled high, then
    // drop the next cycle; the two requests are never high together.
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
    logic        active;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_wen;
    logic        m_ren;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport slave (
        input  addr, wdata, wmask, wen, ren,
        output rdata, ready, active,
        output m_addr, m_wdata, m_wmask, m_wen, m_ren,
        input  m_rdata, m_ready
    );

    modport master (
        output addr, wdata, wmask, wen, ren,
        input  rdata, ready, active,
        input  m_addr, m_wdata, m_wmask, m_wen, m_ren,
        output m_rdata, m_ready
    );

endinterface

// File: rtl/bus_dma_regs.sv
// Register window of bus_dma: address decode, registered read/ready response,
// SRC/DST/LEN storage, DONE/ERROR flags and START/ABORT strobes toward the FSM.
module bus_dma_regs
    import bus_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    input  logic        i_wen,
    input  logic        i_ren,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_active,
    input  logic        i_busy,
    input  logic [15:0] i_remaining,
    input  logic        i_set_done,
    input  logic        i_set_err,
    output logic [31:0] o_src,
    output logic [31:0] o_dst,
    output logic [15:0] o_len,
    output logic        o_launch,
    output logic        o_abort
);

    logic [31:0] w_off;
    logic [1:0]  w_idx;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_start_zero;
    logic [31:0] w_rd_val;

    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic        r_done;
    logic        r_err;
    logic        r_ready;
    logic [31:0] r_rdata;

    // Modulo subtraction makes the window test a single unsigned compare.
    assign w_off        = i_addr - BASE_ADDR;
    assign w_idx        = w_off[3:2];
    assign o_active     = (w_off < 32'd16);
    assign w_wr         = i_wen && o_active && (i_wmask == 4'hF);
    assign w_wr_ctrl    = w_wr && (w_idx == REG_CTRL);
    assign w_start      = w_wr_ctrl && i_wdata[CTRL_START] && !i_busy;
    assign w_start_zero = w_start && (r_len == 16'd0);
    assign o_launch     = w_start && (r_len != 16'd0);
    assign o_abort      = w_wr_ctrl && i_wdata[CTRL_ABORT] && i_busy;

    assign o_src   = r_src;
    assign o_dst   = r_dst;
    assign o_len   = r_len;
    assign o_ready = r_ready;
    assign o_rdata = r_rdata;

    always_comb begin
        w_rd_val = 32'd0;
        case (w_idx)
            REG_SRC: w_rd_val = r_src;
            REG_DST: w_rd_val = r_dst;
            REG_LEN: w_rd_val = {16'd0, r_len};
            default: w_rd_val = pack_ctrl(i_busy, r_done, r_err, i_remaining);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= 32'd0;
            r_dst   <= 32'd0;
            r_len   <= 16'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= (i_wen || i_ren) && o_active;
            r_rdata <= (i_ren && o_active) ? w_rd_val : 32'd0;

            if (w_wr && !i_busy) begin
                case (w_idx)
                    REG_SRC: r_src <= {i_wdata[31:2], 2'b00};
                    REG_DST: r_dst <= {i_wdata[31:2], 2'b00};
                    REG_LEN: r_len <= i_wdata[15:0];
                    default: ;
                endcase
            end

            // Later assignments win: clear, then launch, then hardware set.
            if (w_wr_ctrl && i_wdata[CTRL_DONE])  r_done <= 1'b0;
            if (w_wr_ctrl && i_wdata[CTRL_ERROR]) r_err  <= 1'b0;
            if (o_launch) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_start_zero) begin
                r_done <= 1'b1;
                r_err  <= 1'b0;
            end
            if (i_set_done) r_done <= 1'b1;
            if (i_set_err)  r_err  <= 1'b1;
        end
    end

endmodule

// File: rtl/bus_dma.sv
// Single-channel word copy engine: register window on the device side, a
// read-then-write initiator on the host side, with a per-request watchdog.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    bus_dma_if.slave   bus,
    output logic [1:0] o_dbg_state
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [31:0] w_src;
    logic [31:0] w_dst;
    logic [15:0] w_len;
    logic        w_launch;
    logic        w_abort;
    logic        w_busy;
    logic        w_wd_expire;
    logic        w_beat_done;
    logic        w_last;
    logic        w_set_done;
    logic        w_set_err;
    logic [31:0] w_rdata;
    logic        w_ready;
    logic        w_active;

    logic [1:0]      r_state;
    logic [31:0]     r_src;
    logic [31:0]     r_dst;
    logic [15:0]     r_count;
    logic [WD_W-1:0] r_wd;
    logic            r_abort_pend;
    logic [31:0]     r_m_addr;
    logic [31:0]     r_m_wdata;
    logic [3:0]      r_m_wmask;
    logic            r_m_ren;
    logic            r_m_wen;

    bus_dma_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (bus.addr),
        .i_wdata     (bus.wdata),
        .i_wmask     (bus.wmask),
        .i_wen       (bus.wen),
        .i_ren       (bus.ren),
        .o_rdata     (w_rdata),
        .o_ready     (w_ready),
        .o_active    (w_active),
        .i_busy      (w_busy),
        .i_remaining (r_count),
        .i_set_done  (w_set_done),
        .i_set_err   (w_set_err),
        .o_src       (w_src),
        .o_dst       (w_dst),
        .o_len       (w_len),
        .o_launch    (w_launch),
        .o_abort     (w_abort)
    );

    assign bus.rdata   = w_rdata;
    assign bus.ready   = w_ready;
    assign bus.active  = w_active;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_wmask = r_m_wmask;
    assign bus.m_ren   = r_m_ren;
    assign bus.m_wen   = r_m_wen;
    assign o_dbg_state = r_state;

    assign w_busy      = (r_state != S_IDLE);
    assign w_wd_expire = w_busy && !bus.m_ready && (r_wd == WD_LAST);
    assign w_beat_done = (r_state == S_WR) && bus.m_ready;
    // An abort arriving on the very edge the write completes still ends the run.
    assign w_last      = (r_count == 16'd1) || r_abort_pend || w_abort;
    assign w_set_done  = w_beat_done && w_last;
    assign w_set_err   = w_wd_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_count      <= 16'd0;
            r_wd         <= '0;
            r_abort_pend <= 1'b0;
            r_m_addr     <= 32'd0;
            r_m_wdata    <= 32'd0;
            r_m_wmask    <= 4'h0;
            r_m_ren      <= 1'b0;
            r_m_wen      <= 1'b0;
        end else begin
            if (w_abort) r_abort_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state      <= S_RD;
                        r_src        <= w_src;
                        r_dst        <= w_dst;
                        r_count      <= w_len;
                        r_wd         <= '0;
                        r_abort_pend <= 1'b0;
                        r_m_addr     <= w_src;
                        r_m_wmask    <= 4'h0;
                        r_m_ren      <= 1'b1;
                    end
                end

                S_RD: begin
                    if (bus.m_ready) begin
                        r_state   <= S_WR;
                        r_wd      <= '0;
                        r_m_wdata <= bus.m_rdata;
                        r_m_addr  <= r_dst;
                        r_m_wmask <= 4'hF;
                        r_m_ren   <= 1'b0;
                        r_m_wen   <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_state      <= S_IDLE;
                        r_wd         <= '0;
                        r_abort_pend <= 1'b0;
                        r_m_ren      <= 1'b0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_WR: begin
                    if (bus.m_ready) begin
                        r_wd      <= '0;
                        r_src     <= r_src + 32'd4;
                        r_dst     <= r_dst + 32'd4;
                        r_count   <= r_count - 16'd1;
                        r_m_wen   <= 1'b0;
                        r_m_wmask <= 4'h0;
                        if (w_last) begin
                            r_state      <= S_IDLE;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state  <= S_RD;
                            r_m_addr <= r_src + 32'd4;
                            r_m_ren  <= 1'b1;
                        end
                    end else if (w_wd_expire) begin
                        r_state      <= S_IDLE;
                        r_wd         <= '0;
                        r_abort_pend <= 1'b0;
                        r_m_wen      <= 1'b0;
                        r_m_wmask    <= 4'h0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_m_ren <= 1'b0;
                    r_m_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule
